// File: rtl/ex_div_pkg.sv
// rtl/ex_div_pkg.sv - shared divider state encoding, status constants and sign helpers
package ex_div_pkg;

    localparam int REG_BUS = 32;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_t;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

    function automatic logic [REG_BUS-1:0] cond_neg(input logic [REG_BUS-1:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

    // Magnitude for signed ops; 0x80000000 maps to itself, which is correct as an unsigned value.
    function automatic logic [REG_BUS-1:0] abs_val(input logic [REG_BUS-1:0] v, input logic is_signed);
        return cond_neg(v, is_signed & v[REG_BUS-1]);
    endfunction

endpackage

// File: rtl/ex_div.sv
// rtl/ex_div.sv - multi-cycle radix-2 restoring DIV/DIVU unit feeding the HI/LO write path
module ex_div
    import ex_div_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               annul_i,
    input  logic               signed_div_i,
    input  logic [REG_BUS-1:0] opdata1_i,
    input  logic [REG_BUS-1:0] opdata2_i,
    output logic               stallreq_o,
    output logic               ready_o,
    output logic               whilo_o,
    output logic [REG_BUS-1:0] hi_o,
    output logic [REG_BUS-1:0] lo_o
);

    div_state_t         state, state_nxt;
    logic [4:0]         cnt;
    logic [64:0]        w;
    logic [64:0]        w_shl;
    logic [64:0]        w_step;
    logic [33:0]        diff;
    logic [REG_BUS-1:0] dvs;
    logic               neg_q, neg_r;
    logic [REG_BUS-1:0] hi_r, lo_r;
    logic               start_req;
    logic               accept;

    assign start_req = (start_i == DIV_START);
    assign accept    = (state == DIV_FREE) && start_req && !annul_i;

    // One restoring step: W = {rem, quo}; the extra sign bit of diff says whether to restore.
    always_comb begin
        w_shl  = w << 1;
        diff   = {1'b0, w_shl[64:32]} - {2'b00, dvs};
        w_step = diff[33] ? w_shl : {diff[32:0], w_shl[31:1], 1'b1};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            DIV_FREE: begin
                if (accept)
                    state_nxt = (opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
            end
            DIV_BY_ZERO: state_nxt = annul_i ? DIV_FREE : DIV_END;
            DIV_ON: begin
                if (annul_i)
                    state_nxt = DIV_FREE;
                else if (cnt == 5'd31)
                    state_nxt = DIV_END;
            end
            DIV_END: begin
                if (annul_i || !start_req)
                    state_nxt = DIV_FREE;
            end
            default: state_nxt = DIV_FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DIV_FREE;
            cnt   <= '0;
            w     <= '0;
            dvs   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            hi_r  <= '0;
            lo_r  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                DIV_FREE: begin
                    if (accept) begin
                        w     <= {33'b0, abs_val(opdata1_i, signed_div_i)};
                        dvs   <= abs_val(opdata2_i, signed_div_i);
                        neg_q <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                        neg_r <= signed_div_i & opdata1_i[31];
                        cnt   <= '0;
                        hi_r  <= '0;
                        lo_r  <= '0;
                    end
                end
                DIV_BY_ZERO: begin
                    hi_r <= '0;
                    lo_r <= '0;
                end
                DIV_ON: begin
                    w   <= w_step;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        lo_r <= cond_neg(w_step[31:0], neg_q);
                        hi_r <= cond_neg(w_step[63:32], neg_r);
                    end
                end
                default: ;
            endcase
        end
    end

    assign stallreq_o = accept || (state == DIV_BY_ZERO) || (state == DIV_ON);
    assign ready_o    = (state == DIV_END) ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
    assign whilo_o    = ready_o;
    assign hi_o       = ready_o ? hi_r : '0;
    assign lo_o       = ready_o ? lo_r : '0;

endmodule

// File: tb/tb_ex_div.sv
// tb/tb_ex_div.sv - scoreboard bench for ex_div with directed divide vectors
module tb_ex_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        annul_i;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        stallreq_o;
    logic        ready_o;
    logic        whilo_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    ex_div dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .stallreq_o   (stallreq_o),
        .ready_o      (ready_o),
        .whilo_o      (whilo_o),
        .hi_o         (hi_o),
        .lo_o         (lo_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic ready_q = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: each new result presentation pops one expected entry.
    always @(negedge clk) begin
        if (!rst && ready_o && !ready_q) begin
            if (sb_q.size() == 0) begin
                check("unexpected_ready", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("lo", lo_o, e.lo);
                check("hi", hi_o, e.hi);
                check("whilo", {31'd0, whilo_o}, 32'd1);
                check("stall_in_end", {31'd0, stallreq_o}, 32'd0);
                check("latency", cyc, e.cyc);
            end
        end
        ready_q <= ready_o;
    end

    task automatic do_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input int lat, input int hold);
        int   t0;
        int   n;
        logic stall_ok;
        exp_t e;
        @(negedge clk);
        start_i      = 1'b1;
        signed_div_i = sg;
        opdata1_i    = a;
        opdata2_i    = b;
        #1;
        t0 = cyc;
        check("stall_accept", {31'd0, stallreq_o}, 32'd1);
        e.hi = exp_hi; e.lo = exp_lo; e.cyc = t0 + lat;
        sb_q.push_back(e);
        stall_ok = 1'b1;
        n = 0;
        while (!ready_o && n < 60) begin
            @(negedge clk);
            #1;
            if (!ready_o && !stallreq_o) stall_ok = 1'b0;
            n++;
        end
        check("ready_timeout", {31'd0, ready_o}, 32'd1);
        check("stall_while_busy", {31'd0, stall_ok}, 32'd1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            #1;
            check("hold_ready", {31'd0, ready_o}, 32'd1);
            check("hold_lo", lo_o, exp_lo);
            check("hold_hi", hi_o, exp_hi);
        end
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        #1;
        check("drop_ready", {31'd0, ready_o}, 32'd0);
        check("drop_lo_zero", lo_o, 32'd0);
        check("drop_hi_zero", hi_o, 32'd0);
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
        opdata1_i = '0; opdata2_i = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready", {31'd0, ready_o}, 32'd0);
        check("rst_stall", {31'd0, stallreq_o}, 32'd0);
        check("rst_whilo", {31'd0, whilo_o}, 32'd0);
        check("rst_hi", hi_o, 32'd0);
        check("rst_lo", lo_o, 32'd0);
        rst = 1'b0;

        do_div(1'b0, 32'd100,        32'd7,          32'd2,          32'd14,         33, 2);
        do_div(1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   32'hFFFFFFFD,   33, 0);
        do_div(1'b1, 32'd7,          32'hFFFFFFFE,   32'd1,          32'hFFFFFFFD,   33, 0);
        do_div(1'b1, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   33, 0);
        do_div(1'b0, 32'hFFFFFFFF,   32'd1,          32'd0,          32'hFFFFFFFF,   33, 0);
        do_div(1'b0, 32'hFFFFFFFF,   32'h80000000,   32'h7FFFFFFF,   32'd1,          33, 0);
        do_div(1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'hFFFFFFFE,   32'd14,         33, 0);
        do_div(1'b0, 32'h00001234,   32'd0,          32'd0,          32'd0,          2,  1);

        // Simultaneous start and annul in FREE is ignored.
        @(negedge clk);
        start_i = 1'b1; annul_i = 1'b1; opdata1_i = 32'd100; opdata2_i = 32'd7; signed_div_i = 1'b0;
        #1;
        check("start_annul_stall", {31'd0, stallreq_o}, 32'd0);
        @(negedge clk);
        start_i = 1'b0; annul_i = 1'b0;
        #1;
        check("start_annul_idle", {31'd0, ready_o | stallreq_o}, 32'd0);

        // Annul at T+10 aborts the divide.
        @(negedge clk);
        start_i = 1'b1; opdata1_i = 32'd100; opdata2_i = 32'd7; signed_div_i = 1'b0;
        repeat (10) @(negedge clk);
        annul_i = 1'b1; start_i = 1'b0;
        @(negedge clk);
        annul_i = 1'b0;
        #1;
        check("annul_ready", {31'd0, ready_o}, 32'd0);
        check("annul_stall", {31'd0, stallreq_o}, 32'd0);
        do_div(1'b0, 32'd9, 32'd4, 32'd1, 32'd2, 33, 0);

        // Reset at T+5 clears everything on the next cycle.
        @(negedge clk);
        start_i = 1'b1; opdata1_i = 32'd100; opdata2_i = 32'd7; signed_div_i = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1; start_i = 1'b0;
        @(negedge clk);
        #1;
        check("midrst_stall", {31'd0, stallreq_o}, 32'd0);
        check("midrst_ready", {31'd0, ready_o}, 32'd0);
        check("midrst_hilo", hi_o | lo_o, 32'd0);
        rst = 1'b0;
        repeat (40) @(negedge clk);

        check("sb_empty", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
